spi_page_loader: RTL and testbench
==================================

Name: spi_page_loader

Overview:
- Downstream consumer of the management block's image_number: fetches one bubble page from the external SPI NOR flash for the selected image.
- Streams the page bytes into the page buffer that feeds the bubble interface.
- Issues a single READ (0x03) transaction per request, SPI mode 0, MSB first.

Parameters:
SPI_DIV, 2, master_clock cycles per SCK half-period (≥1); SCK = 48 MHz / (2*SPI_DIV), 12 MHz at default.
ADDR_BITS, 6, log2 of page size in bytes; PAGE_BYTES = 2**ADDR_BITS (64 at default).

Ports:
master_clock  input  1  48 MHz master clock; all logic on rising edge.
reset_n  input  1  synchronous active-low reset.
image_number  input  3  image select from the management block.
page_number  input  12  bubble page to fetch.
load_request  input  1  one-cycle start strobe; honoured only in IDLE.
load_busy  output  1  high from the cycle after an accepted request through the load_done cycle.
load_done  output  1  one-cycle pulse when the page is fully written.
flash_cs_n  output  1  flash chip select, active low.
flash_clk  output  1  SCK, idles low.
flash_mosi  output  1  serial data to flash.
flash_miso  input  1  serial data from flash.
buffer_write_address  output  ADDR_BITS  byte index within the page.
buffer_write_data  output  8  assembled byte.
buffer_write_enable  output  1  one-cycle write strobe.

Behaviour:
- Reset (reset_n=0 at a clock edge) is synchronous and applies regardless of state, including mid-transaction. It forces:
  - state IDLE, flash_cs_n=1, flash_clk=0, flash_mosi=0;
  - load_busy=0, load_done=0, buffer_write_enable=0;
  - buffer_write_address=0, buffer_write_data=0, all counters 0.
- No partial write completes after a mid-transaction reset.
- Accept: in IDLE with load_request=1, latch image_number and page_number.
  - flash address = {image_number, page_number} << ADDR_BITS, truncated/zero-extended to 24 bits.
  - Next cycle: state CS_SETUP, flash_cs_n=0, load_busy=1.
  - load_request in any non-IDLE state is ignored; no queuing.
- States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> DONE -> IDLE.
- CS_SETUP: SPI_DIV cycles, SCK low; flash_mosi holds bit 7 of 0x03.
- SHIFT: 32 + 8*PAGE_BYTES bits. The 32 command/address bits are 0x03 followed by addr[23:0]. Each bit is:
  - SCK low for SPI_DIV cycles with MOSI stable;
  - then SCK high for SPI_DIV cycles.
  - MOSI changes only on the edge that drives SCK low (next bit).
  - flash_miso is sampled on the edge that drives SCK high.
  - During data bits, MOSI is held 0.
- Byte write: on the edge after the 8th data bit of a byte is sampled, buffer_write_enable=1 for exactly one cycle.
  - buffer_write_data is that byte, MSB first as received.
  - buffer_write_address starts at 0 and increments after each write.
  - It wraps to 0 after PAGE_BYTES-1.
- CS_HOLD: after the final high phase, SCK returns low and stays low for SPI_DIV cycles with flash_cs_n still 0.
- DONE: flash_cs_n=1, load_done=1 for one cycle, load_busy=1 during this cycle. Next cycle IDLE with load_busy=0.
- A request in the first IDLE cycle after DONE is accepted (back-to-back allowed).
- Latency: request accepted at cycle 0 → load_done high at cycle 1 + SPI_DIV*(2 + 2*(32 + 8*PAGE_BYTES)), which is 2181 at defaults.
- flash_cs_n never toggles mid-transaction. SCK never pulses while flash_cs_n=1.

Test Plan:
- Reset then idle 100 cycles → flash_cs_n=1, flash_clk=0, load_busy=0, no write strobes.
- image_number=5, page_number=0x123, flash model returns byte k = k^0xA5:
  - MOSI bytes observed are 0x03, 0x14, 0x48, 0xC0;
  - 64 writes at addresses 0..63 with data k^0xA5;
  - load_done pulses exactly 2181 cycles after the request.
- Second load_request at cycle 500 of an active load → ignored. Exactly one 0x03 command, one load_done.
- reset_n=0 at cycle 1000 of a load → next edge flash_cs_n=1, load_busy=0, no further write strobes. A new request afterwards completes normally.
- SPI_DIV=1, image 7, page 0xFFF → address bytes 0x1F, 0xFF, 0xC0; SCK period 2 cycles; load_done at cycle 1091.
- Back-to-back: request in the first IDLE cycle after load_done → accepted, flash_cs_n high for exactly one cycle between transactions.

Source files
------------

// File: rtl/spi_page_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_page_loader_if
// Purpose  : Request, SPI flash and page-buffer signals of the page loader,
//            bundled with a slave (loader) and master (environment) view.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_page_loader_if #(
  parameter int ADDR_BITS = 6
);
  // Request side (management block)
  logic [2:0]           image_number;
  logic [11:0]          page_number;
  logic                 load_request;
  logic                 load_busy;
  logic                 load_done;
  // SPI NOR flash pins
  logic                 flash_cs_n;
  logic                 flash_clk;
  logic                 flash_mosi;
  logic                 flash_miso;
  // Page buffer write port
  logic [ADDR_BITS-1:0] buffer_write_address;
  logic [7:0]           buffer_write_data;
  logic                 buffer_write_enable;

  // Loader side
  modport slave (
    input  image_number, page_number, load_request, flash_miso,
    output load_busy, load_done, flash_cs_n, flash_clk, flash_mosi,
           buffer_write_address, buffer_write_data, buffer_write_enable
  );

  // Environment side (request source, flash device, page buffer)
  modport master (
    output image_number, page_number, load_request, flash_miso,
    input  load_busy, load_done, flash_cs_n, flash_clk, flash_mosi,
           buffer_write_address, buffer_write_data, buffer_write_enable
  );
endinterface
`default_nettype wire

// File: rtl/spi_page_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_page_loader
// Purpose  : Fetches one bubble page from SPI NOR flash with a single READ
//            (0x03) transaction, mode 0, MSB first, and streams the received
//            bytes into the page buffer.
// Revision : 1.0 - initial release
// ============================================================================
module spi_page_loader #(
  parameter int SPI_DIV   = 2,
  parameter int ADDR_BITS = 6
) (
  input  logic             master_clock,
  input  logic             reset_n,
  spi_page_loader_if.slave bus
);

  localparam int PAGE_BYTES = 2 ** ADDR_BITS;
  localparam int c_CMD_BITS = 32;
  localparam int c_NUM_BITS = c_CMD_BITS + 8 * PAGE_BYTES;
  localparam int BIT_W      = $clog2(c_NUM_BITS);
  localparam int DIV_W      = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int FULL_W     = 15 + ADDR_BITS;

  localparam logic [7:0]           c_READ_CMD  = 8'h03;
  localparam logic [DIV_W-1:0]     c_DIV_LAST  = DIV_W'(SPI_DIV - 1);
  localparam logic [DIV_W-1:0]     c_DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0]     c_BIT_LAST  = BIT_W'(c_NUM_BITS - 1);
  localparam logic [BIT_W-1:0]     c_BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]     c_DATA_BIT0 = BIT_W'(c_CMD_BITS);
  localparam logic [ADDR_BITS-1:0] c_ADDR_ONE  = ADDR_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SHIFT    = 3'd2,
    S_CS_HOLD  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                r_state;
  logic [DIV_W-1:0]      r_div;          // cycles spent in current SCK half / CS phase
  logic [BIT_W-1:0]      r_bit;          // index of the bit currently on the wire
  logic [31:0]           r_tx;           // latched command + address, bit 31 is on MOSI
  logic [7:0]            r_rx;           // MISO assembly register
  logic                  r_byte_ready;   // a full byte landed in r_rx on the last edge
  logic                  r_cs_n;
  logic                  r_sck;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_we;
  logic [ADDR_BITS-1:0]  r_waddr;
  logic [7:0]            r_wdata;

  logic [FULL_W-1:0]     w_full_addr;
  logic [23:0]           w_flash_addr;

  // Byte address of the page in flash: {image, page} scaled by the page size
  assign w_full_addr = {bus.image_number, bus.page_number, {ADDR_BITS{1'b0}}};

  generate
    if (FULL_W >= 24) begin : g_addr_trunc
      assign w_flash_addr = w_full_addr[23:0];
    end else begin : g_addr_ext
      assign w_flash_addr = {{(24 - FULL_W){1'b0}}, w_full_addr};
    end
  endgenerate

  // Transaction sequencer: CS framing, SCK generation, shifting and buffer writes
  always_ff @(posedge master_clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_bit        <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_byte_ready <= 1'b0;
      r_cs_n       <= 1'b1;
      r_sck        <= 1'b0;
      r_mosi       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_done       <= 1'b0;
      // The write strobe trails the sampling edge of a byte's last bit by one edge
      r_byte_ready <= 1'b0;
      r_we         <= r_byte_ready;
      if (r_byte_ready) begin
        r_wdata <= r_rx;
      end
      // Address advances once per strobe and wraps naturally at the page size
      if (r_we) begin
        r_waddr <= r_waddr + c_ADDR_ONE;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.load_request) begin
            // The request is latched here as the complete outgoing frame
            r_tx    <= {c_READ_CMD, w_flash_addr};
            r_mosi  <= c_READ_CMD[7];
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_CS_SETUP;
          end
        end

        S_CS_SETUP: begin
          if (r_div == c_DIV_LAST) begin
            r_div   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + c_DIV_ONE;
          end
        end

        S_SHIFT: begin
          if (r_div != c_DIV_LAST) begin
            r_div <= r_div + c_DIV_ONE;
          end else begin
            r_div <= '0;
            if (!r_sck) begin
              // Rising SCK: the flash has held MISO stable for the low phase
              r_sck <= 1'b1;
              r_rx  <= {r_rx[6:0], bus.flash_miso};
              if (r_bit >= c_DATA_BIT0 && r_bit[2:0] == 3'b111) begin
                r_byte_ready <= 1'b1;
              end
            end else begin
              // Falling SCK: present the next bit, zeros once the frame is out
              r_sck <= 1'b0;
              if (r_bit == c_BIT_LAST) begin
                r_mosi  <= 1'b0;
                r_state <= S_CS_HOLD;
              end else begin
                r_bit  <= r_bit + c_BIT_ONE;
                r_tx   <= {r_tx[30:0], 1'b0};
                r_mosi <= r_tx[30];
              end
            end
          end
        end

        S_CS_HOLD: begin
          if (r_div == c_DIV_LAST) begin
            r_div   <= '0;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_div <= r_div + c_DIV_ONE;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_cs_n  <= 1'b1;
          r_sck   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_busy            = r_busy;
  assign bus.load_done            = r_done;
  assign bus.flash_cs_n           = r_cs_n;
  assign bus.flash_clk            = r_sck;
  assign bus.flash_mosi           = r_mosi;
  assign bus.buffer_write_address = r_waddr;
  assign bus.buffer_write_data    = r_wdata;
  assign bus.buffer_write_enable  = r_we;

endmodule
`default_nettype wire

// File: tb/tb_spi_page_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_page_loader
// Purpose  : Scoreboard bench for spi_page_loader: two instances (SPI_DIV=2
//            and SPI_DIV=1), a behavioural SPI flash returning k^0xA5, and a
//            negedge monitor popping expected writes, commands and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_page_loader;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  spi_page_loader_if #(.ADDR_BITS(6)) ifa ();
  spi_page_loader_if #(.ADDR_BITS(6)) ifb ();

  spi_page_loader #(.SPI_DIV(2), .ADDR_BITS(6)) dut_a (
    .master_clock (clk),
    .reset_n      (rst_a_n),
    .bus          (ifa.slave)
  );

  spi_page_loader #(.SPI_DIV(1), .ADDR_BITS(6)) dut_b (
    .master_clock (clk),
    .reset_n      (rst_b_n),
    .bus          (ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard queues, index 0 = dut_a, 1 = dut_b
  logic [15:0] wq [2][$];   // {address, data} of each expected buffer write
  logic [31:0] cq [2][$];   // expected 32-bit command/address frame
  int          lq [2][$];   // expected request-to-load_done latency in cycles
  int          req_cyc [2];
  int          fcnt [2];    // SCK rising edges seen by the flash model
  logic [31:0] fcmd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=event expected=none", name);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares each DUT output event with the head of its queue
  task automatic mon(input int i, input logic we, input logic [5:0] wa, input logic [7:0] wd,
                     input logic done, input logic req, input logic busy,
                     input logic cs_n, input logic sck);
    logic [15:0] e;
    if (req && !busy && !done) req_cyc[i] = cyc;
    if (we) begin
      if (wq[i].size() == 0) fail($sformatf("dut%0d_write_unexpected", i));
      else begin
        e = wq[i].pop_front();
        chk($sformatf("dut%0d_wr_addr", i), 32'(wa), 32'(e[15:8]));
        chk($sformatf("dut%0d_wr_data", i), 32'(wd), 32'(e[7:0]));
      end
    end
    if (done) begin
      if (lq[i].size() == 0) fail($sformatf("dut%0d_done_unexpected", i));
      else chk($sformatf("dut%0d_latency", i), 32'(cyc - req_cyc[i]), 32'(lq[i].pop_front()));
    end
    if (cs_n) chk($sformatf("dut%0d_sck_while_cs_high", i), 32'(sck), 32'd0);
  endtask

  always @(negedge clk) begin
    mon(0, ifa.buffer_write_enable, ifa.buffer_write_address, ifa.buffer_write_data,
        ifa.load_done, ifa.load_request, ifa.load_busy, ifa.flash_cs_n, ifa.flash_clk);
    mon(1, ifb.buffer_write_enable, ifb.buffer_write_address, ifb.buffer_write_data,
        ifb.load_done, ifb.load_request, ifb.load_busy, ifb.flash_cs_n, ifb.flash_clk);
  end

  // Flash model: collects the frame on rising SCK, then presents data byte k = k^0xA5
  task automatic flash_rise(input int i, input logic mosi, output logic miso);
    int d;
    logic [7:0] b;
    if (fcnt[i] < 32) fcmd[i] = {fcmd[i][30:0], mosi};
    fcnt[i]++;
    if (fcnt[i] == 32) begin
      if (cq[i].size() == 0) fail($sformatf("dut%0d_cmd_unexpected", i));
      else chk($sformatf("dut%0d_cmd_frame", i), fcmd[i], cq[i].pop_front());
    end
    miso = 1'b0;
    if (fcnt[i] >= 32) begin
      d = fcnt[i] - 32;
      b = 8'(d / 8) ^ 8'hA5;
      miso = b[7 - (d % 8)];
    end
  endtask

  always @(negedge ifa.flash_cs_n) fcnt[0] = 0;
  always @(negedge ifb.flash_cs_n) fcnt[1] = 0;

  always @(posedge ifa.flash_clk) begin
    logic m;
    if (!ifa.flash_cs_n) begin
      flash_rise(0, ifa.flash_mosi, m);
      ifa.flash_miso = m;
    end
  end

  always @(posedge ifb.flash_clk) begin
    logic m;
    if (!ifb.flash_cs_n) begin
      flash_rise(1, ifb.flash_mosi, m);
      ifb.flash_miso = m;
    end
  end

  task automatic push_page(input int i);
    for (int k = 0; k < 64; k++) wq[i].push_back({8'(k), 8'(k) ^ 8'hA5});
  endtask

  // Called #1 after a rising edge: request high for exactly one cycle
  task automatic issue(input int i, input logic [2:0] img, input logic [11:0] pg);
    if (i == 0) begin
      ifa.image_number = img; ifa.page_number = pg; ifa.load_request = 1'b1;
    end else begin
      ifb.image_number = img; ifb.page_number = pg; ifb.load_request = 1'b1;
    end
    @(posedge clk); #1;
    ifa.load_request = 1'b0;
    ifb.load_request = 1'b0;
  endtask

  task automatic wait_done(input int i, input int max);
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if ((i == 0) ? ifa.load_done : ifb.load_done) return;
    end
    fail($sformatf("dut%0d_done_timeout", i));
  endtask

  task automatic drained(input int i);
    chk($sformatf("dut%0d_writes_left", i), 32'(wq[i].size()), 32'd0);
    chk($sformatf("dut%0d_cmds_left", i), 32'(cq[i].size()), 32'd0);
    chk($sformatf("dut%0d_dones_left", i), 32'(lq[i].size()), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.image_number = '0; ifa.page_number = '0; ifa.load_request = 1'b0; ifa.flash_miso = 1'b0;
    ifb.image_number = '0; ifb.page_number = '0; ifb.load_request = 1'b0; ifb.flash_miso = 1'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs_n", 32'(ifa.flash_cs_n), 32'd1);
    chk("reset_wr_addr", 32'(ifa.buffer_write_address), 32'd0);
    chk("reset_wr_data", 32'(ifa.buffer_write_data), 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Idle after reset: nothing moves, no strobes
    repeat (100) @(posedge clk);
    #1;
    chk("idle_cs_n", 32'(ifa.flash_cs_n), 32'd1);
    chk("idle_sck", 32'(ifa.flash_clk), 32'd0);
    chk("idle_busy", 32'(ifa.load_busy), 32'd0);
    chk("idle_b_cs_n", 32'(ifb.flash_cs_n), 32'd1);

    // Image 5 page 0x123 -> address 0x1448C0; extra request at cycle 500 ignored
    push_page(0);
    cq[0].push_back(32'h031448C0);
    lq[0].push_back(2181);
    issue(0, 3'd5, 12'h123);
    chk("accept_cs_n", 32'(ifa.flash_cs_n), 32'd0);
    chk("accept_busy", 32'(ifa.load_busy), 32'd1);
    repeat (498) @(posedge clk);
    #1;
    issue(0, 3'd1, 12'h777);
    wait_done(0, 3000);
    repeat (20) @(posedge clk);
    #1;
    chk("after_done_busy", 32'(ifa.load_busy), 32'd0);
    drained(0);

    // Reset in the middle of a load: frame 0x091580, aborted at cycle 1000
    push_page(0);
    cq[0].push_back(32'h03091580);
    lq[0].push_back(2181);
    issue(0, 3'd2, 12'h456);
    repeat (998) @(posedge clk);
    #1;
    rst_a_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_cs_n", 32'(ifa.flash_cs_n), 32'd1);
    chk("midreset_busy", 32'(ifa.load_busy), 32'd0);
    chk("midreset_sck", 32'(ifa.flash_clk), 32'd0);
    chk("midreset_we", 32'(ifa.buffer_write_enable), 32'd0);
    chk("midreset_wr_addr", 32'(ifa.buffer_write_address), 32'd0);
    wq[0].delete();
    lq[0].delete();
    rst_a_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    push_page(0);
    cq[0].push_back(32'h03040040);
    lq[0].push_back(2181);
    issue(0, 3'd1, 12'h001);
    wait_done(0, 3000);
    repeat (5) @(posedge clk);
    #1;
    drained(0);

    // SPI_DIV=1, image 7 page 0xFFF -> address 0x1FFFC0, SCK period 2 cycles
    push_page(1);
    cq[1].push_back(32'h031FFFC0);
    lq[1].push_back(1091);
    issue(1, 3'd7, 12'hFFF);
    begin
      int n;
      n = 0;
      while (!ifb.flash_clk && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b_sck_seen", 32'(ifb.flash_clk), 32'd1);
      @(negedge clk);
      chk("b_sck_low", 32'(ifb.flash_clk), 32'd0);
      @(negedge clk);
      chk("b_sck_high", 32'(ifb.flash_clk), 32'd1);
    end
    wait_done(1, 2000);
    repeat (5) @(posedge clk);
    #1;
    drained(1);

    // Back-to-back on dut_a: second request in the first IDLE cycle after DONE
    push_page(0);
    cq[0].push_back(32'h030C2AC0);
    lq[0].push_back(2181);
    issue(0, 3'd3, 12'h0AB);
    wait_done(0, 3000);
    push_page(0);
    cq[0].push_back(32'h03120000);
    lq[0].push_back(2181);
    @(posedge clk);
    #1;
    chk("b2b_idle_cs_n", 32'(ifa.flash_cs_n), 32'd1);
    chk("b2b_idle_busy", 32'(ifa.load_busy), 32'd0);
    issue(0, 3'd4, 12'h800);
    chk("b2b_accept_cs_n", 32'(ifa.flash_cs_n), 32'd0);
    chk("b2b_accept_busy", 32'(ifa.load_busy), 32'd1);
    wait_done(0, 3000);
    repeat (10) @(posedge clk);
    #1;
    drained(0);
    drained(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
